// File: rtl/alu_exec.sv
// alu_exec: registered execute-stage ALU with a valid/ready handshake.
//
// One operation is accepted per cycle when in_valid && in_ready. The result
// and its flags are held in an output register until the downstream stage
// takes them (out_valid && out_ready). A new operation can load on the same
// edge that the old result is consumed, so there is no bubble.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  request handshake (in_ready = !out_valid || out_ready)
//   aluctl, a, b        operation code and operands
//   out_valid, out_ready result handshake
//   result, zero, ovf, illegal  registered result and flags
//   err_sticky          set by any accepted illegal op, cleared only by reset
//   op_count            results consumed downstream, wraps silently
module alu_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OpAnd = 4'd0;
  localparam logic [3:0] OpOr  = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd6;
  localparam logic [3:0] OpSlt = 4'd7;
  localparam logic [3:0] OpNor = 4'd12;
  localparam logic [3:0] OpXor = 4'd13;

  logic [WIDTH-1:0] sum, diff, result_d, result_q;
  logic             slt, ovf_d, ovf_q, illegal_d, illegal_q, zero_q;
  logic             out_valid_q, err_sticky_q;
  logic [CNT_W-1:0] op_count_q;
  logic             accept, consume;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  assign sum  = a + b;
  assign diff = a - b;
  // Differing signs decide the compare directly; equal signs cannot overflow.
  assign slt  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];

  always_comb begin
    result_d  = '0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (aluctl)
      OpAnd: result_d = a & b;
      OpOr:  result_d = a | b;
      OpAdd: begin
        result_d = sum;
        ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        result_d = diff;
        ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpSlt: result_d = {{(WIDTH-1){1'b0}}, slt};
      OpNor: result_d = ~(a | b);
      OpXor: result_d = a ^ b;
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      illegal_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      out_valid_q <= accept || (out_valid_q && !consume);
      if (accept) begin
        result_q  <= result_d;
        zero_q    <= (result_d == '0);
        ovf_q     <= ovf_d;
        illegal_q <= illegal_d;
        if (illegal_d) err_sticky_q <= 1'b1;
      end
      if (consume) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;
  assign illegal    = illegal_q;
  assign err_sticky = err_sticky_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec. Inputs change and outputs are sampled
// 1 time unit after each rising edge. op_count is narrowed to 4 bits so the
// wrap case is reachable in a few cycles.
module tb_alu_exec;

  localparam int unsigned W = 32;
  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   aluctl;
  logic [W-1:0] a, b, result;
  logic         zero, ovf, illegal, err_sticky;
  logic [C-1:0] op_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluctl(aluctl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .illegal(illegal),
    .err_sticky(err_sticky), .op_count(op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    aluctl   = op;
    a        = x;
    b        = y;
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    aluctl = 4'd2; a = 32'd1; b = 32'd1;
    step(); step();
    nvec++;
    if ({out_valid, result, zero, ovf, illegal, err_sticky, op_count} !== '0) begin
      nerr++;
      $display("FAIL reset_state got v=%b r=%h z=%b o=%b i=%b e=%b c=%0d want all zero",
               out_valid, result, zero, ovf, illegal, err_sticky, op_count);
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    apply_reset();
    out_ready = 1'b1;
    set_op(4'd2, 32'd5, 32'd7);
    step();
    in_valid = 1'b0;
    nvec++;
    if ({out_valid, result, zero, ovf} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL add_5_7 got v=%b r=%h z=%b o=%b want v=1 r=0000000c z=0 o=0",
               out_valid, result, zero, ovf);
    end
    step();
    nvec++;
    if ({out_valid, op_count, result} !== {1'b0, 4'd1, 32'd12}) begin
      nerr++;
      $display("FAIL add_consume got v=%b c=%0d r=%h want v=0 c=1 r=0000000c",
               out_valid, op_count, result);
    end
    step();  // idle cycle: nothing may change
    nvec++;
    if ({out_valid, op_count, result} !== {1'b0, 4'd1, 32'd12}) begin
      nerr++;
      $display("FAIL idle_hold got v=%b c=%0d r=%h want v=0 c=1 r=0000000c",
               out_valid, op_count, result);
    end
  endtask

  task automatic test_arith_flags();
    out_ready = 1'b1;
    set_op(4'd2, 32'h7FFF_FFFF, 32'd1);
    step();
    nvec++;
    if ({result, ovf, zero} !== {32'h8000_0000, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL add_ovf got r=%h o=%b z=%b want r=80000000 o=1 z=0", result, ovf, zero);
    end
    set_op(4'd6, 32'h8000_0000, 32'd1);
    step();
    nvec++;
    if ({result, ovf} !== {32'h7FFF_FFFF, 1'b1}) begin
      nerr++; $display("FAIL sub_ovf got r=%h o=%b want r=7fffffff o=1", result, ovf);
    end
    set_op(4'd6, 32'd9, 32'd9);
    step();
    nvec++;
    if ({result, zero, ovf} !== {32'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL sub_zero got r=%h z=%b o=%b want r=0 z=1 o=0", result, zero, ovf);
    end
    set_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  // -1 + -1: no overflow
    step();
    nvec++;
    if ({result, ovf} !== {32'hFFFF_FFFE, 1'b0}) begin
      nerr++; $display("FAIL add_neg got r=%h o=%b want r=fffffffe o=0", result, ovf);
    end
    set_op(4'd6, 32'd0, 32'h8000_0000);  // 0 - min overflows
    step();
    nvec++;
    if ({result, ovf} !== {32'h8000_0000, 1'b1}) begin
      nerr++; $display("FAIL sub_min got r=%h o=%b want r=80000000 o=1", result, ovf);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_slt_logic();
    logic [3:0]   ops [0:7];
    logic [W-1:0] va  [0:7];
    logic [W-1:0] vb  [0:7];
    logic [W-1:0] exp [0:7];
    ops = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd0, 4'd1, 4'd13, 4'd12};
    va  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'd1,
            32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
    vb  = '{32'd1, 32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFF,
            32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00};
    exp = '{32'd1, 32'd1, 32'd0, 32'd0,
            32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F};
    out_ready = 1'b1;
    // Back-to-back issue: a new op is accepted every cycle.
    for (int i = 0; i < 8; i++) begin
      set_op(ops[i], va[i], vb[i]);
      step();
      nvec++;
      if ({out_valid, result, ovf, illegal} !== {1'b1, exp[i], 1'b0, 1'b0}) begin
        nerr++;
        $display("FAIL op%0d_code%0d got v=%b r=%h o=%b i=%b want v=1 r=%h o=0 i=0",
                 i, ops[i], out_valid, result, ovf, illegal, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    set_op(4'd2, 32'd1, 32'd1);
    step();
    set_op(4'd6, 32'd10, 32'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++;
      if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 32'd2}) begin
        nerr++;
        $display("FAIL stall%0d got rdy=%b v=%b r=%h want rdy=0 v=1 r=00000002",
                 i, in_ready, out_valid, result);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_ready_comb got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    nvec++;
    if ({out_valid, result, op_count} !== {1'b1, 32'd6, 4'd1}) begin
      nerr++;
      $display("FAIL bp_swap got v=%b r=%h c=%0d want v=1 r=00000006 c=1",
               out_valid, result, op_count);
    end
    step();
    nvec++;
    if ({out_valid, op_count} !== {1'b0, 4'd2}) begin
      nerr++; $display("FAIL bp_count got v=%b c=%0d want v=0 c=2", out_valid, op_count);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    set_op(4'd4, 32'd1, 32'd1);
    step();
    nvec++;
    if ({result, illegal, zero, ovf, err_sticky} !== {32'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL illegal4 got r=%h i=%b z=%b o=%b e=%b want r=0 i=1 z=1 o=0 e=1",
               result, illegal, zero, ovf, err_sticky);
    end
    set_op(4'd2, 32'd2, 32'd2);
    step();
    in_valid = 1'b0;
    nvec++;
    if ({result, illegal, err_sticky} !== {32'd4, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL after_illegal got r=%h i=%b e=%b want r=00000004 i=0 e=1",
               result, illegal, err_sticky);
    end
    step();
  endtask

  task automatic test_wrap();
    apply_reset();
    out_ready = 1'b1;
    set_op(4'd1, 32'd0, 32'd0);
    for (int i = 0; i < 16; i++) step();
    nvec++;
    if (op_count !== 4'd15) begin
      nerr++; $display("FAIL count_15 got %0d want 15", op_count);
    end
    in_valid = 1'b0;
    step();
    nvec++;
    if ({op_count, out_valid} !== {4'd0, 1'b0}) begin
      nerr++; $display("FAIL count_wrap got c=%0d v=%b want c=0 v=0", op_count, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(4'd13, 32'd5, 32'd5);
    step();
    set_op(4'd3, 32'd3, 32'd3);  // illegal, so err_sticky would set if accepted
    out_ready = 1'b1;
    step();
    nvec++;
    if (err_sticky !== 1'b1) begin
      nerr++; $display("FAIL pre_reset_err got %b want 1", err_sticky);
    end
    out_ready = 1'b0;
    step();
    reset = 1'b1; out_ready = 1'b1;  // consume/accept during reset must be ignored
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    nvec++;
    if ({out_valid, op_count, err_sticky, in_ready, result, illegal} !==
        {1'b0, 4'd0, 1'b0, 1'b1, 32'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_mid got v=%b c=%0d e=%b rdy=%b r=%h i=%b want v=0 c=0 e=0 rdy=1 r=0 i=0",
               out_valid, op_count, err_sticky, in_ready, result, illegal);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluctl = '0; a = '0; b = '0;
    test_reset();
    test_add();
    test_arith_flags();
    test_slt_logic();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Registered execute-stage ALU that consumes the 4-bit `aluctl` operation code produced by the ALU control decoder and performs the selected operation on two operands. It sits between the decode/control logic and the writeback path of the MIPS datapath, accepting one operation per cycle through a valid/ready handshake and holding its result in an output register until the downstream stage accepts it. It also flags signed overflow, zero results and unsupported operation codes.

## Interface
- `WIDTH`, 32, operand and result width in bits (≥ 2)
- `CNT_W`, 16, width of the completed-operation counter
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  operation request present
- `in_ready`  output  1  block can accept a request this cycle
- `aluctl`  input  4  operation code
- `a`  input  WIDTH  operand A (rs)
- `b`  input  WIDTH  operand B (rt or immediate)
- `out_valid`  output  1  result register holds an unconsumed result
- `out_ready`  input  1  downstream accepts the result this cycle
- `result`  output  WIDTH  registered result
- `zero`  output  1  registered `result == 0`
- `ovf`  output  1  registered signed overflow (add/sub only)
- `illegal`  output  1  registered: the op code was unsupported
- `err_sticky`  output  1  set by any accepted illegal op; cleared only by reset
- `op_count`  output  CNT_W  number of results consumed downstream, wraps modulo 2^CNT_W

## Operation
- Op codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, 13 XOR. Every other code is illegal.
- ADD/SUB are modulo 2^WIDTH.
  - `ovf` = operand sign bits agree (ADD) or differ (SUB), and the result sign differs from `a`'s sign.
  - `ovf` is 0 for all other ops.
- SLT is a signed compare. `result` = 1 if `a < b`, else 0. Computed without overflow error (compare sign-aware, not via wrapped subtraction sign alone).
- Illegal code:
  - `result` = 0, `zero` = 1, `ovf` = 0, `illegal` = 1.
  - `err_sticky` sets on the same edge the result is loaded.
- Accept condition: `in_valid && in_ready`.
  - On accept, `result`, `zero`, `ovf` and `illegal` load from the combinational computation.
  - `out_valid` is then 1.
- Consume condition: `out_valid && out_ready`.
  - `op_count` increments by 1.
  - `out_valid` clears unless a new accept occurs in the same cycle.
- Simultaneous accept and consume: the new result replaces the old one and `out_valid` stays 1. No bubble.
- While `out_valid && !out_ready`:
  - `result`, `zero`, `ovf` and `illegal` hold.
  - Input is stalled.
- Inputs are ignored when `in_valid` = 0. Registered outputs are unchanged in that case.

## Timing
- `in_ready` = `!out_valid || out_ready` (combinational from `out_ready`). No combinational path from `in_valid` to `in_ready`.
- Latency: 1 cycle. A request accepted at edge N has its result visible after edge N with `out_valid` = 1.
- Throughput: 1 op/cycle while `out_ready` = 1.
- Reset, checked at a clock edge with `reset` = 1:
  - `out_valid` = 0, `result` = 0, `zero` = 0, `ovf` = 0, `illegal` = 0, `err_sticky` = 0, `op_count` = 0.
  - `in_ready` = 1 in the cycle after reset.
- Reset mid-operation: a pending unconsumed result is discarded. Any accept or consume in the reset cycle has no effect.
- `op_count` wraps from 2^CNT_W−1 to 0 with no flag.
- Registered outputs never change while `out_valid` = 1 and `out_ready` = 0.

## Test plan
- Reset, then hold `out_ready` = 1 and issue ADD `a`=5, `b`=7 → one cycle later `out_valid` = 1, `result` = 12, `zero` = 0, `ovf` = 0. The cycle after that, `op_count` = 1.
- ADD `a`=0x7FFFFFFF, `b`=1 → `result` = 0x80000000, `ovf` = 1. SUB `a`=0x80000000, `b`=1 → `result` = 0x7FFFFFFF, `ovf` = 1. SUB `a`=9, `b`=9 → `result` = 0, `zero` = 1, `ovf` = 0.
- SLT `a`=0xFFFFFFFF, `b`=1 → `result` = 1. SLT `a`=0x80000000, `b`=0x7FFFFFFF → `result` = 1. SLT `a`=3, `b`=3 → `result` = 0. In the same run: AND, OR, XOR and NOR of 0xF0F0F0F0 with 0xFF00FF00 → 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F.
- Backpressure: issue ADD 1+1 with `out_ready` = 0 for 3 cycles while `in_valid` stays 1 with a second request SUB 10−4.
  - While stalled, `in_ready` = 0 and `result` holds 2.
  - When `out_ready` rises, 2 is consumed and 6 loads on the same edge with `out_valid` staying 1.
  - `op_count` = 2 after both are consumed.
- Issue illegal code 4 with `a`=1, `b`=1 → `result` = 0, `illegal` = 1, `zero` = 1, `err_sticky` = 1. A following legal ADD 2+2 gives `illegal` = 0 while `err_sticky` stays 1.
- Assert `reset` while `out_valid` = 1 and `out_ready` = 0 → next cycle `out_valid` = 0, `op_count` = 0, `err_sticky` = 0, `in_ready` = 1.
